// File: rtl/ex_div.sv
// ex_div: multi-cycle RV32M divide/remainder unit for the execute stage.
// Runs a radix-2 restoring divider for 32 iterations. While it works it
// holds the pipeline through stall_o, then returns one result strobe that
// carries the destination register.
module ex_div (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   input  logic [4:0]  rd_addr_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        busy_o,
   output logic        valid_o,
   output logic        regs_wen_o,
   output logic [4:0]  rd_addr_o,
   output logic [31:0] result_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [4:0]  cnt;
   logic [31:0] dvd;
   logic [31:0] dsr;
   logic [31:0] quo;
   logic [31:0] rem;
   logic        rem_sel_q;
   logic        neg_quo_q;
   logic        neg_rem_q;
   logic [4:0]  rd_q;

   logic        launch;
   logic        signed_op;
   logic        dvd_neg;
   logic        dsr_neg;
   logic [31:0] dvd_mag;
   logic [31:0] dsr_mag;

   logic [32:0] rem_shift;
   logic [32:0] rem_diff;
   logic [31:0] rem_nxt;
   logic [31:0] quo_nxt;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   // Launch decode and operand magnitudes; signed ops divide absolute values
   always_comb begin
      launch    = start_i & ~flush_i;
      signed_op = ~op_i[0];
      dvd_neg   = signed_op & dividend_i[31];
      dsr_neg   = signed_op & divisor_i[31];
      dvd_mag   = dvd_neg ? (~dividend_i + 32'd1) : dividend_i;
      dsr_mag   = dsr_neg ? (~divisor_i + 32'd1) : divisor_i;
   end

   // One restoring step; the borrow out of the 33-bit subtract decides the quotient bit,
   // and the sign fix-up is applied to the values this final step produces
   always_comb begin
      rem_shift = {rem, dvd[31]};
      rem_diff  = rem_shift - {1'b0, dsr};
      if (!rem_diff[32]) begin
         rem_nxt = rem_diff[31:0];
         quo_nxt = {quo[30:0], 1'b1};
      end else begin
         rem_nxt = rem_shift[31:0];
         quo_nxt = {quo[30:0], 1'b0};
      end
      quo_fix = neg_quo_q ? (~quo_nxt + 32'd1) : quo_nxt;
      rem_fix = neg_rem_q ? (~rem_nxt + 32'd1) : rem_nxt;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs; flush always returns to IDLE without a strobe
   always_comb begin
      state_nxt = state;
      stall_o   = 1'b0;
      busy_o    = 1'b0;
      valid_o   = 1'b0;
      case (state)
         IDLE: begin
            if (launch) begin
               stall_o   = 1'b1;
               state_nxt = (divisor_i == 32'd0) ? DONE : CALC;
            end
         end
         CALC: begin
            stall_o = 1'b1;
            busy_o  = 1'b1;
            if (flush_i) begin
               state_nxt = IDLE;
            end else if (cnt == 5'd31) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy_o    = 1'b1;
            valid_o   = ~flush_i;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign regs_wen_o = valid_o;

   // Datapath: capture on launch, iterate in CALC, register the fixed-up result entering DONE
   always_ff @(posedge clk) begin
      if (rstn) begin
         cnt       <= 5'd0;
         dvd       <= 32'd0;
         dsr       <= 32'd0;
         quo       <= 32'd0;
         rem       <= 32'd0;
         rem_sel_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         rd_q      <= 5'd0;
         rd_addr_o <= 5'd0;
         result_o  <= 32'd0;
      end else if (state == IDLE) begin
         if (launch) begin
            if (divisor_i != 32'd0) begin
               cnt       <= 5'd0;
               dvd       <= dvd_mag;
               dsr       <= dsr_mag;
               quo       <= 32'd0;
               rem       <= 32'd0;
               rem_sel_q <= op_i[1];
               neg_quo_q <= dvd_neg ^ dsr_neg;
               neg_rem_q <= dvd_neg;
               rd_q      <= rd_addr_i;
            end else begin
               result_o  <= op_i[1] ? dividend_i : 32'hFFFF_FFFF;
               rd_addr_o <= rd_addr_i;
            end
         end
      end else if (state == CALC) begin
         if (!flush_i) begin
            dvd <= {dvd[30:0], 1'b0};
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
               result_o  <= rem_sel_q ? rem_fix : quo_fix;
               rd_addr_o <= rd_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed test of the ex_div divide controller against a
// latency/arithmetic reference model checked on every cycle.
module tb_ex_div;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic [4:0]  rd_addr_i;
   logic        flush_i;
   logic        stall_o;
   logic        busy_o;
   logic        valid_o;
   logic        regs_wen_o;
   logic [4:0]  rd_addr_o;
   logic [31:0] result_o;

   int errors = 0;
   int checks = 0;

   // Reference model state: cycles remaining until the result strobe (0 = idle)
   int          togo = 0;
   logic [31:0] pend_res = '0;
   logic [31:0] hold_res = '0;
   logic [4:0]  pend_rd = '0;
   logic [4:0]  hold_rd = '0;
   logic        exp_stall;
   logic        exp_busy;
   logic        exp_valid;
   bit          chk_en = 0;
   int          valid_total = 0;

   ex_div dut (
      .clk        (clk),
      .rstn       (rstn),
      .start_i    (start_i),
      .op_i       (op_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .rd_addr_i  (rd_addr_i),
      .flush_i    (flush_i),
      .stall_o    (stall_o),
      .busy_o     (busy_o),
      .valid_o    (valid_o),
      .regs_wen_o (regs_wen_o),
      .rd_addr_o  (rd_addr_o),
      .result_o   (result_o)
   );

   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
      end
   endtask

   // RV32M results from plain arithmetic, including divide-by-zero and overflow rules
   function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (op[0]) return op[1] ? (a % b) : (a / b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      return op[1] ? (sa % sb) : (sa / sb);
   endfunction

   // Compare process: check every output each cycle, then advance the model
   always @(negedge clk) begin
      if (togo > 0) begin
         exp_busy  = 1'b1;
         exp_stall = (togo > 1);
         exp_valid = (togo == 1) && !flush_i;
      end else begin
         exp_busy  = 1'b0;
         exp_stall = start_i && !flush_i;
         exp_valid = 1'b0;
      end
      if (valid_o === 1'b1) valid_total++;
      if (chk_en) begin
         checkOutput("cyc_stall", {31'd0, stall_o}, {31'd0, exp_stall});
         checkOutput("cyc_busy", {31'd0, busy_o}, {31'd0, exp_busy});
         checkOutput("cyc_valid", {31'd0, valid_o}, {31'd0, exp_valid});
         checkOutput("cyc_wen", {31'd0, regs_wen_o}, {31'd0, exp_valid});
         checkOutput("cyc_rd", {27'd0, rd_addr_o}, {27'd0, hold_rd});
         checkOutput("cyc_result", result_o, hold_res);
      end
      if (rstn) begin
         togo     = 0;
         hold_res = '0;
         hold_rd  = '0;
      end else if (flush_i) begin
         togo = 0;
      end else if (togo == 0) begin
         if (start_i) begin
            pend_res = refResult(op_i, dividend_i, divisor_i);
            pend_rd  = rd_addr_i;
            togo     = (divisor_i == 32'd0) ? 1 : 33;
         end
      end else begin
         togo--;
      end
      if (togo == 1) begin
         hold_res = pend_res;
         hold_rd  = pend_rd;
      end
   end

   // Launch one operation in the current cycle and wait (bounded) for its strobe
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input bit hold, output int lat,
                                output logic [31:0] res, output logic [4:0] rda, output int stalls);
      bit found;
      int c;
      start_i    = 1'b1;
      op_i       = op;
      dividend_i = a;
      divisor_i  = b;
      rd_addr_i  = rd;
      found  = 0;
      c      = 0;
      lat    = -1;
      res    = '0;
      rda    = '0;
      stalls = 0;
      while (!found && c < 100) begin
         @(negedge clk);
         if (stall_o) stalls++;
         if (valid_o) begin
            found = 1;
            lat   = c;
            res   = result_o;
            rda   = rd_addr_o;
         end
         @(posedge clk);
         #1;
         if (!hold || found) start_i = 1'b0;
         c++;
      end
   endtask

   task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hold, input logic [31:0] exp_res, input int exp_lat);
      int          lat;
      int          stalls;
      logic [31:0] res;
      logic [4:0]  rda;
      applyStimulus(op, a, b, rd, hold, lat, res, rda, stalls);
      checkOutput({name, "_result"}, res, exp_res);
      checkOutput({name, "_latency"}, lat, exp_lat);
      checkOutput({name, "_rd"}, {27'd0, rda}, {27'd0, rd});
      checkOutput({name, "_stall_cycles"}, stalls, exp_lat);
   endtask

   initial begin
      int v0;
      rstn       = 1'b1;
      start_i    = 1'b0;
      op_i       = 2'd0;
      dividend_i = '0;
      divisor_i  = '0;
      rd_addr_i  = '0;
      flush_i    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn   = 1'b0;
      chk_en = 1;
      @(negedge clk);
      checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
      checkOutput("reset_valid", {31'd0, valid_o}, 32'd0);
      checkOutput("reset_result", result_o, 32'd0);
      checkOutput("reset_rd", {27'd0, rd_addr_o}, 32'd0);
      @(posedge clk);
      #1;

      $display("[TB] unsigned and signed division");
      runOp("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 0, 32'h0000_000E, 33);
      runOp("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd5, 0, 32'h0000_0002, 33);
      runOp("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 32'hFFFF_FFFD, 33);
      runOp("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 32'hFFFF_FFFF, 33);
      runOp("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 5'd7, 0, 32'hFFFF_FFFD, 33);
      runOp("div_100_m7", 2'b00, 32'd100, 32'hFFFF_FFF9, 5'd8, 0, 32'hFFFF_FFF2, 33);
      runOp("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 5'd8, 0, 32'h0000_0002, 33);
      runOp("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 5'd8, 0, 32'hFFFF_FFFE, 33);
      runOp("remu_big", 2'b11, 32'h1234_5678, 32'h0000_0100, 5'd31, 0, 32'h0000_0078, 33);
      runOp("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd1, 0, 32'hFFFF_FFFF, 33);

      $display("[TB] divide by zero and overflow");
      runOp("divu_by0", 2'b01, 32'd5, 32'd0, 5'd3, 0, 32'hFFFF_FFFF, 1);
      runOp("rem_by0", 2'b10, 32'hFFFF_FFF9, 32'd0, 5'd4, 0, 32'hFFFF_FFF9, 1);
      runOp("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, 32'h8000_0000, 33);
      runOp("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 32'h0000_0000, 33);

      $display("[TB] flush coincident with start");
      start_i    = 1'b1;
      flush_i    = 1'b1;
      op_i       = 2'b01;
      dividend_i = 32'd50;
      divisor_i  = 32'd5;
      rd_addr_i  = 5'd2;
      @(negedge clk);
      checkOutput("flushstart_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      flush_i = 1'b0;
      checkOutput("flushstart_busy", {31'd0, busy_o}, 32'd0);

      $display("[TB] flush mid-operation");
      v0         = valid_total;
      start_i    = 1'b1;
      op_i       = 2'b01;
      dividend_i = 32'd1000;
      divisor_i  = 32'd3;
      rd_addr_i  = 5'd7;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         start_i = 1'b0;
         if (c == 10) flush_i = 1'b1;
      end
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      checkOutput("flush_busy_k1", {31'd0, busy_o}, 32'd0);
      checkOutput("flush_stall_k1", {31'd0, stall_o}, 32'd0);
      runOp("after_flush", 2'b01, 32'd1000, 32'd10, 5'd9, 0, 32'h0000_0064, 33);
      checkOutput("flush_valid_pulses", valid_total - v0, 32'd1);

      $display("[TB] start held high, then reset mid-operation");
      v0 = valid_total;
      runOp("held_start", 2'b01, 32'hFFFF_FFFF, 32'd3, 5'd12, 1, 32'h5555_5555, 33);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("held_valid_pulses", valid_total - v0, 32'd1);
      start_i    = 1'b1;
      op_i       = 2'b00;
      dividend_i = 32'h1234_5678;
      divisor_i  = 32'hFFFF_FFFB;
      rd_addr_i  = 5'd13;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         start_i = 1'b0;
         if (c == 20) rstn = 1'b1;
      end
      @(posedge clk);
      #1;
      rstn = 1'b0;
      checkOutput("rst_stall", {31'd0, stall_o}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
      checkOutput("rst_valid", {31'd0, valid_o}, 32'd0);
      checkOutput("rst_wen", {31'd0, regs_wen_o}, 32'd0);
      checkOutput("rst_rd", {27'd0, rd_addr_o}, 32'd0);
      checkOutput("rst_result", result_o, 32'd0);
      v0 = valid_total;
      repeat (40) begin
         @(posedge clk);
         #1;
      end
      checkOutput("rst_no_valid", valid_total - v0, 32'd0);
      runOp("after_reset", 2'b00, 32'd100, 32'd7, 5'd14, 0, 32'h0000_000E, 33);

      repeat (2) begin
         @(posedge clk);
         #1;
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle integer divide controller for the execute stage, handling the RV32M DIV, DIVU, REM and REMU instructions. The execute stage launches an operation with a start pulse. The block then runs a radix-2 restoring divider for 32 iterations and holds the pipeline through a stall request. It returns the quotient or remainder with its destination register and write-enable, using the execute stage's writeback fields. It sits beside the single-cycle ALU in ex and is sequenced by its own FSM.

## Interface
- No parameters; data width is fixed at 32 (`RegBus`), register address width at 5 (`RegAddrBus`).
- clk  in  1  core clock; all state changes on rising edge
- rstn  in  1  reset, synchronous, active-high (1 = reset)
- start_i  in  1  launch request, sampled only in IDLE
- op_i  in  2  operation = funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend_i  in  32  rs1 value (op1)
- divisor_i  in  32  rs2 value (op2)
- rd_addr_i  in  5  destination register
- flush_i  in  1  abort any operation in progress (branch/trap)
- stall_o  out  1  pipeline hold request
- busy_o  out  1  high in CALC and DONE
- valid_o  out  1  one-cycle result strobe
- regs_wen_o  out  1  equals valid_o
- rd_addr_o  out  5  captured rd_addr_i
- result_o  out  32  quotient or remainder

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE -> CALC when start_i=1, flush_i=0 and divisor_i!=0.
  - Capture op, rd_addr, sign flags and the magnitudes of both operands.
  - Magnitudes are two's-complement absolute values for DIV/REM and raw values for DIVU/REMU.
  - Clear the 5-bit iteration counter, the quotient register and the 33-bit partial remainder.
- IDLE -> DONE directly when start_i=1, flush_i=0 and divisor_i==0 (divide-by-zero fast path).
  - Quotient = 0xFFFFFFFF.
  - Remainder = dividend_i unmodified.
  - Sign fix-up is skipped.
- CALC iteration, one per cycle:
  - rem = {rem[31:0], dvd[31]}; shift dvd left by 1.
  - If rem >= {0,dsr}: rem -= dsr and quotient bit = 1; else quotient bit = 0.
  - Leave CALC for DONE after the iteration with counter==31.
- Sign fix-up, on entry to DONE:
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder is negated if the dividend was negative (signed ops only).
  - The fix-up is registered into result_o at the CALC->DONE transition.
- result_o selects the quotient for op_i[1]=0 and the remainder for op_i[1]=1.
- Overflow case 0x80000000 / 0xFFFFFFFF (DIV/REM) needs no special path: the algorithm yields quotient 0x80000000 and remainder 0.
- DONE -> IDLE unconditionally after one cycle.
- stall_o = (IDLE & start_i & ~flush_i) | CALC. It is low in DONE so ex/mem advances with the result.
- start_i outside IDLE is ignored; no queuing.
- flush_i in any state: next state is IDLE, valid_o is not asserted for the aborted operation, and captured data is discarded.
- flush_i coincident with start_i in IDLE: flush_i wins and the operation is not launched.
- Reset: state=IDLE, counter=0, valid_o=0, regs_wen_o=0, busy_o=0, stall_o=0, rd_addr_o=0, result_o=0.
- result_o and rd_addr_o hold their last values until the next DONE.

## Timing
- Cycle 0: start_i sampled in IDLE; stall_o=1 combinationally.
- Cycles 1..32: CALC, stall_o=1, busy_o=1.
- Cycle 33: DONE, valid_o=regs_wen_o=1, stall_o=0.
- Cycle 34: IDLE; a new start_i is accepted in this cycle.
- Normal latency is 33 cycles start-to-valid, with throughput one operation per 34 cycles.
- Divide-by-zero: valid_o in cycle 1; IDLE in cycle 2.
- Flush asserted in cycle k: IDLE in cycle k+1; stall_o and busy_o are low from k+1.
- Reset asserted mid-CALC: IDLE on the next edge with all outputs at reset values.

## Test plan
- DIVU 100/7, rd=5: valid_o at cycle 33, result_o=0x0000000E, rd_addr_o=5, stall_o high for cycles 0-32 only. REMU on the same operands gives 0x00000002.
- DIV 0xFFFFFFF9(-7)/2 gives 0xFFFFFFFD. REM on the same operands gives 0xFFFFFFFF. DIV 7/0xFFFFFFFE(-2) gives 0xFFFFFFFD.
- DIVU 5/0 gives 0xFFFFFFFF at cycle 1. REM 0xFFFFFFF9/0 gives 0xFFFFFFF9. No CALC cycles occur.
- DIV 0x80000000/0xFFFFFFFF gives 0x80000000. REM on the same operands gives 0x00000000. Latency is 33 cycles.
- Launch DIVU, then assert flush_i at cycle 10. valid_o is never asserted and busy_o is 0 at cycle 11. A start_i at cycle 11 launches a new operation, which completes at cycle 44 with the correct result.
- start_i held high throughout an operation: only one valid_o pulse occurs. Assert rstn at cycle 20 of a second operation: all outputs are 0 on the next cycle and there is no valid_o.
